obj_field_engine: RTL and testbench
===================================

Name: obj_field_engine

Overview:
- Parametrised successor of the fixed 5-slot game logic: manages N_OBJ scrolling objects (collectables/hazards), collision against the player, score/health, and the START/PLAY/OVER game FSM.
- Sits between the VGA timing/frame-tick source and the sprite renderer. Outputs a packed object bus, score and health.
- Slot updates are serialised, one slot per clock, after each frame tick, so area does not scale with parallel comparators.

Parameters:
- N_OBJ, 8, number of object slots (2..16)
- SCREEN_WIDTH, 1024, spawn horizontal position (1..2047)
- CHAR_WIDTH, 20, player hit-box width in px
- CHAR_HEIGHT, 20, player hit-box height in px
- OBJ_HEIGHT, 20, object hit-box height in px
- NUM_LIVES, 3, health loaded at game start (1..7)
- SCORE_W, 10, score width; score saturates at all-ones
- VPOS_MIN, 230, base vertical spawn position
- SPAWN_BITS, 6, spawn when rand[31:32-SPAWN_BITS]==0
- INVULN_FRAMES, 60, frames of invulnerability after a hit (optional feature only)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle start request (e.g. midi_ready)
- frame_tick  in  1  one-cycle pulse per VGA frame
- speed  in  4  px per frame scroll
- p_vpos  in  10  player vertical position
- rand  in  32  random word, sampled in SPAWN
- objs  out  26*N_OBJ  slot i at [26i+25:26i]: [25:23] frame, [22:21] identity (0 collectable, 1 hazard), [20:10] hpos, [9:0] vpos; all-zero = empty
- score  out  SCORE_W  current score
- health  out  3  remaining lives
- game_state  out  2  0 START, 1 PLAY, 2 OVER
- busy  out  1  high during SWEEP/SPAWN
- collect_p  out  1  one-cycle pulse per collectable consumed
- hit_p  out  1  one-cycle pulse per hazard consumed
- overrun  out  1  sticky; set if frame_tick arrives while busy

Behaviour:
- Reset (any cycle, including mid-sweep): all slots 0, score 0, health NUM_LIVES, game_state START, busy 0, pulses 0, overrun 0, frame counter 0, slot index 0.
- All outputs are registered.
- START: slots held 0, score 0, health NUM_LIVES. On start, go to PLAY next cycle.
- PLAY/IDLE: on frame_tick, increment the 3-bit frame counter fc, set busy, enter SWEEP with idx=0.
- SWEEP: takes one cycle per slot, idx 0..N_OBJ-1. Per occupied slot, in priority order:
  - (1) Collision check on pre-move values: hpos<CHAR_WIDTH AND vpos<p_vpos+CHAR_HEIGHT AND vpos+OBJ_HEIGHT>p_vpos. Use 11-bit arithmetic; no underflow.
    - On collision the slot is cleared.
    - Identity 0: score+1 (saturating), collect_p.
    - Identity 1: health-1 (not below 0), hit_p.
  - (2) Else if hpos<=speed: slot cleared (off-screen).
  - (3) Else hpos-=speed. If fc==0, frame field +1 (wraps 7->0).
  - Empty slots are untouched.
- SPAWN: one cycle after idx N_OBJ-1.
  - If rand[31:32-SPAWN_BITS]==0 and any slot is empty, the lowest-index empty slot is loaded with: frame 0, identity {1'b0,rand[0]}, hpos SCREEN_WIDTH, vpos VPOS_MIN+rand[8:1] (10-bit, wraps).
  - At most one spawn per frame.
  - Then busy drops. If health==0, go to OVER; else stay PLAY/IDLE.
- Total latency frame_tick -> busy low = N_OBJ+2 cycles. Collision results are visible the cycle after that slot's sweep cycle.
- frame_tick while busy: ignored, overrun set; the sweep continues unaffected.
- OVER: slots frozen, score/health held. On start, clear slots, score 0, health NUM_LIVES, go to PLAY.
- start in PLAY: ignored.
- speed==0: objects stationary. Collisions are still checked.

Optional Feature:
- Macro OBJ_FIELD_INVULN_EN.
- Defined:
  - A hazard hit loads an invuln counter with INVULN_FRAMES.
  - The counter decrements once per frame_tick.
  - While it is nonzero, hazard collisions still clear the slot and pulse hit_p, but health does not change.
  - Reset and game start clear the counter.
- Undefined: no counter exists; every hazard hit decrements health.

Test Plan:
- Reset then start: game_state 0->1, health=3, score=0, objs=0, busy 0.
- Force rand=0 (N_OBJ=8, speed=4): after first frame_tick, slot0 = hpos 1024, vpos 230, identity 0, within 10 cycles. After the next tick, hpos=1020 and slot1 is spawned.
- Collectable at hpos 10, vpos 300, p_vpos 295: one tick -> slot cleared, score +1, collect_p one cycle. Same setup with vpos 276: vpos+OBJ_HEIGHT=296>295, so collision. With vpos 275: no collision, hpos becomes 6.
- Three hazards hit on consecutive frames: health 3->2->1->0, then game_state=2 at end of sweep. Start -> PLAY, health=3, score=0.
- Object at hpos 4 with speed 4: cleared after tick with no score change. Second frame_tick during busy -> overrun=1, sweep completes normally.
- With OBJ_FIELD_INVULN_EN, INVULN_FRAMES=2: hazards on frames 1, 2, 3 -> health 3,2,2,2 (frames 2 and 3 fall inside the window), hit_p on all three; hazard on frame 4 -> health 1.

Source files
------------

// File: rtl/obj_field_engine.sv
// obj_field_engine: N_OBJ scrolling object slots with player collision,
// score/health bookkeeping and the START/PLAY/OVER game FSM.
// Slots are swept serially, one per clock, after every frame tick.
// Optional feature: define OBJ_FIELD_INVULN_EN for post-hit invulnerability.
// "rand" is a reserved word, so the random input port is named rand_word.
module obj_field_engine #(
    parameter int N_OBJ         = 8,
    parameter int SCREEN_WIDTH  = 1024,
    parameter int CHAR_WIDTH    = 20,
    parameter int CHAR_HEIGHT   = 20,
    parameter int OBJ_HEIGHT    = 20,
    parameter int NUM_LIVES     = 3,
    parameter int SCORE_W       = 10,
    parameter int VPOS_MIN      = 230,
    parameter int SPAWN_BITS    = 6,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 frame_tick,
    input  logic [3:0]           speed,
    input  logic [9:0]           p_vpos,
    input  logic [31:0]          rand_word,
    output logic [26*N_OBJ-1:0]  objs,
    output logic [SCORE_W-1:0]   score,
    output logic [2:0]           health,
    output logic [1:0]           game_state,
    output logic                 busy,
    output logic                 collect_p,
    output logic                 hit_p,
    output logic                 overrun
);
    localparam int IDX_W = $clog2(N_OBJ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

    typedef enum logic [2:0] {ST_START, ST_IDLE, ST_SWEEP, ST_SPAWN, ST_OVER} state_t;
    state_t state, next_state;

    logic [25:0]      slots [N_OBJ];
    logic [IDX_W-1:0] idx;
    logic [2:0]       fc;
    logic             game_start;

    logic [25:0]      cur, swept;
    logic [10:0]      hpos_cur, vpos_ext, pv_ext;
    logic             collide, sweep_collect, sweep_hit;

    logic             have_empty, spawn_ok;
    logic [IDX_W-1:0] empty_idx;
    logic [9:0]       spawn_vpos;
    logic [25:0]      spawn_slot;
    logic             health_dmg_en;

    logic             unused_rand;
    assign unused_rand = ^rand_word;

    assign game_start = start && (state == ST_START || state == ST_OVER);

`ifdef OBJ_FIELD_INVULN_EN
    localparam int INV_W = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);
    logic [INV_W-1:0] invuln_cnt;
    logic             invuln_act;

    assign health_dmg_en = !invuln_act;

    // Protection is decided at each frame tick, so one hit shields the following INVULN_FRAMES frames
    always_ff @(posedge clock) begin
        if (reset || game_start) begin
            invuln_cnt <= '0;
            invuln_act <= 1'b0;
        end else if (state == ST_IDLE && frame_tick) begin
            invuln_act <= (invuln_cnt != '0);
            if (invuln_cnt != '0)
                invuln_cnt <= invuln_cnt - 1'b1;
        end else if (state == ST_SWEEP && sweep_hit && !invuln_act) begin
            invuln_cnt <= INV_W'(INVULN_FRAMES);
        end
    end
`else
    logic [31:0] unused_invuln;
    assign unused_invuln = 32'(INVULN_FRAMES);
    assign health_dmg_en = 1'b1;
`endif

    // Evaluate the slot under the sweep pointer: collision first, then off-screen, then scroll
    always_comb begin
        cur           = slots[idx];
        hpos_cur      = cur[20:10];
        vpos_ext      = {1'b0, cur[9:0]};
        pv_ext        = {1'b0, p_vpos};
        collide       = (hpos_cur < 11'(CHAR_WIDTH)) &&
                        (vpos_ext < pv_ext + 11'(CHAR_HEIGHT)) &&
                        (vpos_ext + 11'(OBJ_HEIGHT) > pv_ext);
        swept         = cur;
        sweep_collect = 1'b0;
        sweep_hit     = 1'b0;
        if (cur != '0) begin
            if (collide) begin
                swept = '0;
                if (cur[22:21] == 2'd0)
                    sweep_collect = 1'b1;
                else
                    sweep_hit = 1'b1;
            end else if (hpos_cur <= {7'd0, speed}) begin
                swept = '0;
            end else begin
                swept[20:10] = hpos_cur - {7'd0, speed};
                if (fc == 3'd0)
                    swept[25:23] = cur[25:23] + 3'd1;
            end
        end
    end

    // Find the lowest-index empty slot and build the candidate spawn record
    always_comb begin
        have_empty = 1'b0;
        empty_idx  = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (slots[i] == '0) begin
                have_empty = 1'b1;
                empty_idx  = IDX_W'(i);
            end
        end
        spawn_vpos = 10'(VPOS_MIN) + {2'b00, rand_word[8:1]};
        spawn_slot = {3'd0, 1'b0, rand_word[0], 11'(SCREEN_WIDTH), spawn_vpos};
        spawn_ok   = have_empty && (rand_word[31:32-SPAWN_BITS] == '0);
    end

    // Game FSM state register
    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_START;
        else
            state <= next_state;
    end

    // Game FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_START: if (start) next_state = ST_IDLE;
            ST_IDLE:  if (frame_tick) next_state = ST_SWEEP;
            ST_SWEEP: if (idx == LAST_IDX) next_state = ST_SPAWN;
            ST_SPAWN: next_state = (health == 3'd0) ? ST_OVER : ST_IDLE;
            ST_OVER:  if (start) next_state = ST_IDLE;
            default:  next_state = ST_START;
        endcase
    end

    // Registered status outputs decoded from the upcoming state
    always_ff @(posedge clock) begin
        if (reset) begin
            game_state <= 2'd0;
            busy       <= 1'b0;
        end else begin
            game_state <= (next_state == ST_START) ? 2'd0 :
                          (next_state == ST_OVER)  ? 2'd2 : 2'd1;
            busy       <= (next_state == ST_SWEEP) || (next_state == ST_SPAWN);
        end
    end

    // Slot storage, score, health, sweep pointer, frame counter and event pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_OBJ; i++)
                slots[i] <= '0;
            score     <= '0;
            health    <= 3'(NUM_LIVES);
            idx       <= '0;
            fc        <= 3'd0;
            collect_p <= 1'b0;
            hit_p     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            collect_p <= 1'b0;
            hit_p     <= 1'b0;
            if (frame_tick && busy)
                overrun <= 1'b1;
            if (game_start) begin
                for (int i = 0; i < N_OBJ; i++)
                    slots[i] <= '0;
                score  <= '0;
                health <= 3'(NUM_LIVES);
                idx    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (frame_tick) begin
                            fc  <= fc + 3'd1;
                            idx <= '0;
                        end
                    end
                    ST_SWEEP: begin
                        slots[idx] <= swept;
                        collect_p  <= sweep_collect;
                        hit_p      <= sweep_hit;
                        if (sweep_collect && score != '1)
                            score <= score + 1'b1;
                        if (sweep_hit && health_dmg_en && health != 3'd0)
                            health <= health - 3'd1;
                        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end
                    ST_SPAWN: begin
                        if (spawn_ok)
                            slots[empty_idx] <= spawn_slot;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Flatten slot storage onto the packed object bus
    always_comb begin
        objs = '0;
        for (int i = 0; i < N_OBJ; i++)
            objs[26*i +: 26] = slots[i];
    end
endmodule

// File: tb/tb_obj_field_engine.sv
// Directed testbench for obj_field_engine (default parameters, N_OBJ = 8).
// Objects are brought into position by spawning at SCREEN_WIDTH and
// scrolling them with chosen speeds; expectations are hand-computed.
module tb_obj_field_engine;
    localparam int N_OBJ = 8;
    localparam logic [31:0] NOSPAWN = 32'hFC00_0000;
`ifdef OBJ_FIELD_INVULN_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset, start, frame_tick;
    logic [3:0]           speed;
    logic [9:0]           p_vpos;
    logic [31:0]          rand_word;
    logic [26*N_OBJ-1:0]  objs;
    logic [9:0]           score;
    logic [2:0]           health;
    logic [1:0]           game_state;
    logic                 busy, collect_p, hit_p, overrun;

    int vec_count = 0;
    int miscompare_count = 0;
    int lat, n_collect, n_hit;

    always #5 clock = ~clock;

    obj_field_engine #(.N_OBJ(N_OBJ)) dut (
        .clock(clock), .reset(reset), .start(start), .frame_tick(frame_tick),
        .speed(speed), .p_vpos(p_vpos), .rand_word(rand_word), .objs(objs),
        .score(score), .health(health), .game_state(game_state), .busy(busy),
        .collect_p(collect_p), .hit_p(hit_p), .overrun(overrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slot(input int i);
        return {6'd0, objs[26*i +: 26]};
    endfunction

    function automatic logic [31:0] mk(input int fr, input int id, input int hp, input int vp);
        return {6'd0, 3'(fr), 2'(id), 11'(hp), 10'(vp)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One frame: pulse frame_tick, then wait (bounded) for busy to drop,
    // counting event pulses and cycles from the tick cycle to busy low.
    task automatic applyStimulus(input logic [3:0] spd, input logic [31:0] rnd,
                                 input logic [9:0] pv, input bit dbl);
        speed = spd; rand_word = rnd; p_vpos = pv; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        lat = 1; n_collect = 0; n_hit = 0;
        while (busy && lat < 20) begin
            step();
            lat++;
            frame_tick = (dbl && lat == 4);
            n_collect += int'(collect_p);
            n_hit     += int'(hit_p);
        end
        frame_tick = 1'b0;
        if (busy) checkOutput("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic travel(input int n15);
        repeat (n15) applyStimulus(4'd15, NOSPAWN, 10'd0, 1'b0);
        applyStimulus(4'd9, NOSPAWN, 10'd0, 1'b0);
    endtask

    task automatic restart();
        reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
        step();
        reset = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int vps [3];
        bit coll [3];
        vps  = '{300, 276, 275};
        coll = '{1'b1, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
        speed = 4'd0; p_vpos = 10'd0; rand_word = NOSPAWN;
        step(); step();
        $display("[TB] reset and start");
        checkOutput("rst_state",   32'(game_state), 32'd0);
        checkOutput("rst_health",  32'(health), 32'd3);
        checkOutput("rst_score",   32'(score), 32'd0);
        checkOutput("rst_objs_nz", 32'(objs != '0), 32'd0);
        checkOutput("rst_busy",    32'(busy), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        step();
        checkOutput("start_wait_state", 32'(game_state), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        checkOutput("play_state",  32'(game_state), 32'd1);
        checkOutput("play_health", 32'(health), 32'd3);
        checkOutput("play_score",  32'(score), 32'd0);
        checkOutput("play_objs_nz", 32'(objs != '0), 32'd0);
        checkOutput("play_busy",   32'(busy), 32'd0);

        $display("[TB] spawn and scroll");
        restart();
        applyStimulus(4'd4, 32'd0, 10'd0, 1'b0);
        checkOutput("spawn_latency", 32'(lat), 32'd10);
        checkOutput("spawn_slot0",   slot(0), mk(0, 0, 1024, 230));
        checkOutput("spawn_slot1",   slot(1), 32'd0);
        applyStimulus(4'd4, 32'd0, 10'd0, 1'b0);
        checkOutput("scroll_slot0",  slot(0), mk(0, 0, 1020, 230));
        checkOutput("scroll_slot1",  slot(1), mk(0, 0, 1024, 230));
        repeat (6) applyStimulus(4'd4, NOSPAWN, 10'd0, 1'b0);
        checkOutput("frame_slot0",   slot(0), mk(1, 0, 996, 230));
        checkOutput("frame_slot1",   slot(1), mk(1, 0, 1000, 230));
        checkOutput("frame_slot2",   slot(2), 32'd0);

        $display("[TB] collectable collision boundaries");
        for (int c = 0; c < 3; c++) begin
            restart();
            applyStimulus(4'd0, 32'(2 * (vps[c] - 230)), 10'd0, 1'b0);
            travel(67);
            checkOutput("coll_pre_slot0", slot(0), mk(0, 0, 10, vps[c]));
            applyStimulus(4'd4, NOSPAWN, 10'd295, 1'b0);
            checkOutput("coll_slot0",   slot(0), coll[c] ? 32'd0 : mk(0, 0, 6, vps[c]));
            checkOutput("coll_score",   32'(score), coll[c] ? 32'd1 : 32'd0);
            checkOutput("coll_pulses",  32'(n_collect), coll[c] ? 32'd1 : 32'd0);
            checkOutput("coll_hits",    32'(n_hit), 32'd0);
        end

        $display("[TB] start ignored in play, off-screen clear, overrun");
        start = 1'b1; step(); start = 1'b0;
        checkOutput("play_start_state", 32'(game_state), 32'd1);
        checkOutput("play_start_slot0", slot(0), mk(0, 0, 6, 275));
        applyStimulus(4'd2, NOSPAWN, 10'd0, 1'b0);
        checkOutput("edge_slot0",      slot(0), mk(0, 0, 4, 275));
        checkOutput("overrun_before",  32'(overrun), 32'd0);
        applyStimulus(4'd4, NOSPAWN, 10'd0, 1'b1);
        checkOutput("offscreen_slot0", slot(0), 32'd0);
        checkOutput("offscreen_score", 32'(score), 32'd0);
        checkOutput("offscreen_pulse", 32'(n_collect), 32'd0);
        checkOutput("overrun_after",   32'(overrun), 32'd1);
        checkOutput("overrun_latency", 32'(lat), 32'd10);

        $display("[TB] hazards on consecutive frames");
        restart();
        applyStimulus(4'd0,  32'd141, 10'd0, 1'b0);
        applyStimulus(4'd15, 32'd141, 10'd0, 1'b0);
        applyStimulus(4'd15, 32'd141, 10'd0, 1'b0);
        travel(65);
        checkOutput("haz_pre_slot0", slot(0), mk(0, 1, 10, 300));
        checkOutput("haz_pre_slot2", slot(2), mk(0, 1, 40, 300));
        for (int j = 1; j <= 3; j++) begin
            applyStimulus(4'd15, NOSPAWN, 10'd295, 1'b0);
            checkOutput("haz_hit_pulse", 32'(n_hit), 32'd1);
            checkOutput("haz_slot",      slot(j - 1), 32'd0);
            checkOutput("haz_health",    32'(health), INV ? 32'd2 : 32'(3 - j));
            checkOutput("haz_score",     32'(score), 32'd0);
            checkOutput("haz_state",     32'(game_state), (!INV && j == 3) ? 32'd2 : 32'd1);
        end
        start = 1'b1; step(); start = 1'b0;
        checkOutput("restart_state",   32'(game_state), 32'd1);
        checkOutput("restart_health",  32'(health), INV ? 32'd2 : 32'd3);
        checkOutput("restart_score",   32'(score), 32'd0);
        checkOutput("restart_objs_nz", 32'(objs != '0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end
endmodule
